// File: rtl/game_controller.sv
// ---------------------------------------------------------------------------
// game_controller
//
// Frame-level sequencer for the dodging game. Runs the IDLE / PLAY / HIT /
// OVER state machine, keeps the lives count and a four-digit BCD score, and
// drives pixel_generation's motion controls (motion_en, restart, blink,
// speed).
//
// Parameters
//   LIVES       lives loaded at game start (1..7)
//   HIT_FRAMES  frames of post-hit invulnerability (1..63)
//   SCORE_DIV   play frames per score point (1..63)
//
// Optional feature
//   GAME_CTRL_DIFFICULTY_EN  when defined, speed steps up by one (max 4)
//                            every time the score reaches a multiple of 100.
//                            When undefined, speed is a constant 1.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   start_btn     raw start button (asynchronous to clk)
//   refresh_tick  one-clk pulse per frame
//   collision     square/obstacle pixel overlap this clk
//   video_on      active-display qualifier
//   motion_en     square position may update on refresh_tick
//   restart       one-clk pulse: reload square position/velocity
//   blink         suppress drawing of the square
//   game_over     high in OVER
//   lives         remaining lives
//   score         four BCD digits, [15:12] = thousands
//   speed         velocity magnitude
//   state         IDLE=0, PLAY=1, HIT=2, OVER=3
// ---------------------------------------------------------------------------
module game_controller #(
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 60,
  parameter int SCORE_DIV  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        refresh_tick,
  input  logic        collision,
  input  logic        video_on,
  output logic        motion_en,
  output logic        restart,
  output logic        blink,
  output logic        game_over,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [2:0]  speed,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_e;

  // BCD increment with a ripple carry through the four digits; 9999 holds.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Start-button synchronizer (two flops) plus one flop for edge detect.
  logic sync1_q, sync2_q, sync3_q;

  state_e      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  hit_cnt_q, hit_cnt_d;
  logic        coll_f_q, coll_f_d;
  logic        motion_en_q, motion_en_d;
  logic        restart_q, restart_d;
  logic        blink_q, blink_d;
  logic        game_over_q, game_over_d;
`ifdef GAME_CTRL_DIFFICULTY_EN
  logic [2:0]  speed_q, speed_d;
`endif

  logic start_pulse;
  logic frame_hit;   // collision seen during the frame being evaluated
  logic score_frame; // this tick counts as a scoring frame

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    start_pulse = sync2_q & ~sync3_q;
    // A collision in the same clk as the tick belongs to the closing frame.
    frame_hit   = coll_f_q | (collision & video_on);
    coll_f_d    = refresh_tick ? 1'b0 : frame_hit;

    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    div_cnt_d   = div_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    restart_d   = 1'b0;
    score_frame = 1'b0;
`ifdef GAME_CTRL_DIFFICULTY_EN
    speed_d     = speed_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        lives_d = 3'(LIVES);
        if (start_pulse) begin
          state_d   = S_PLAY;
          restart_d = 1'b1;
          score_d   = 16'h0000;
          div_cnt_d = 6'd0;
`ifdef GAME_CTRL_DIFFICULTY_EN
          speed_d   = 3'd1;
`endif
        end
      end
      S_PLAY: begin
        if (refresh_tick) begin
          if (frame_hit) begin
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_d = S_OVER;
            end else begin
              state_d   = S_HIT;
              hit_cnt_d = 6'd0;
            end
          end else begin
            score_frame = 1'b1;
          end
        end
      end
      S_HIT: begin
        if (refresh_tick) begin
          score_frame = 1'b1;
          hit_cnt_d   = hit_cnt_q + 6'd1;
          if (hit_cnt_q == 6'(HIT_FRAMES - 1)) state_d = S_PLAY;
        end
      end
      S_OVER: begin
        // lives reloads on the way out so IDLE always shows the full count.
        if (start_pulse) begin
          state_d = S_IDLE;
          lives_d = 3'(LIVES);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (score_frame) begin
      if (div_cnt_q == 6'(SCORE_DIV - 1)) begin
        div_cnt_d = 6'd0;
        score_d   = bcd_inc(score_q);
`ifdef GAME_CTRL_DIFFICULTY_EN
        // A held 9999 keeps its low digits at 99, so saturation never levels.
        if (score_d[7:0] == 8'h00 && speed_q < 3'd4) speed_d = speed_q + 3'd1;
`endif
      end else begin
        div_cnt_d = div_cnt_q + 6'd1;
      end
    end

    // Outputs are registered from the next-state view so they line up with
    // the state register.
    motion_en_d = (state_d == S_PLAY) || (state_d == S_HIT);
    game_over_d = (state_d == S_OVER);
    blink_d     = (state_d == S_HIT) && hit_cnt_d[2];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      state_q     <= S_IDLE;
      lives_q     <= 3'(LIVES);
      score_q     <= 16'h0000;
      div_cnt_q   <= 6'd0;
      hit_cnt_q   <= 6'd0;
      coll_f_q    <= 1'b0;
      motion_en_q <= 1'b0;
      restart_q   <= 1'b0;
      blink_q     <= 1'b0;
      game_over_q <= 1'b0;
`ifdef GAME_CTRL_DIFFICULTY_EN
      speed_q     <= 3'd1;
`endif
    end else begin
      sync1_q     <= start_btn;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      div_cnt_q   <= div_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      coll_f_q    <= coll_f_d;
      motion_en_q <= motion_en_d;
      restart_q   <= restart_d;
      blink_q     <= blink_d;
      game_over_q <= game_over_d;
`ifdef GAME_CTRL_DIFFICULTY_EN
      speed_q     <= speed_d;
`endif
    end
  end

  assign motion_en = motion_en_q;
  assign restart   = restart_q;
  assign blink     = blink_q;
  assign game_over = game_over_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign state     = state_q;
`ifdef GAME_CTRL_DIFFICULTY_EN
  assign speed     = speed_q;
`else
  assign speed     = 3'd1;
`endif

endmodule
